moving_avg_srl_inverse: RTL and testbench
=========================================

# moving_avg_srl_inverse

Reconstructs the original sample stream from the N-point running-sum stream produced by the team's moving-average filter, i.e. the decoder for that encoder. It sits downstream of a filter that exposes its unshifted accumulator. It inverts x[n] = s[n] − s[n−1] + x[n−N] exactly, one sample per clock. The block is used for loop-back verification of the filter path and for recovering raw samples from a sum-only link.

## Interface
- WIDTH, 16, recovered sample width (signed)
- N, 16, window length; 1..32; must equal 2^SHIFT
- SHIFT, 4, log2(N); SUM_WIDTH = WIDTH + SHIFT
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_sum valid this cycle; no backpressure
- in_sum  in  SUM_WIDTH  signed running sum s[n] from upstream filter
- flush  in  1  synchronous re-sync: clear history and previous sum
- err_clr  in  1  synchronous clear of range_err
- out_valid  out  1  out_sample valid this cycle
- out_sample  out  WIDTH  signed recovered sample x[n]
- range_err  out  1  sticky: a recovered value was saturated

## Operation
- State:
  - prev_sum (SUM_WIDTH, signed): last accepted in_sum.
  - hist[0..N−1] (WIDTH each): delay line of recovered samples. hist[N−1] = x[n−N].
- Per accepted sample (in_valid=1):
  - diff = in_sum − prev_sum, computed at SUM_WIDTH+1 bits.
  - r = diff + sext(hist[N−1]), computed at SUM_WIDTH+2 bits.
  - If r > 2^(WIDTH−1)−1 or r < −2^(WIDTH−1): xs = clamped limit and range_err ← 1. Otherwise xs = r[WIDTH−1:0].
  - prev_sum ← in_sum.
  - hist shifts by one: hist[0] ← xs.
  - out_sample ← xs.
- in_valid=0: no state changes; out_sample holds its last value.
- The history is zero at start, matching the upstream filter's zero-initialised delay line. There is no warm-up period; every accepted input yields a valid output.
- flush=1 (priority over normal update):
  - The computation uses prev_sum=0 and hist[N−1]=0.
  - All hist entries are cleared.
  - If in_valid=1 in the same cycle, the sample is treated as the first sample after clear: hist[0] ← xs, prev_sum ← in_sum, output produced.
  - If in_valid=0: prev_sum ← 0 and no output.
- err_clr=1 clears range_err. If a saturation occurs in the same cycle, the set wins and range_err = 1.
- Delay line: behavioural shift register in simulation; may map to SRLC32E per bit under SYNTHESIS. flush clearing must work in both builds. The SRL path realises clearing with a zero-valid mask counter (0..N) that forces hist[N−1] reads to 0 until N samples have entered after a flush.

## Timing
- Reset values (rst=1, asynchronous): out_valid=0, out_sample=0, range_err=0, prev_sum=0, all hist=0, mask counter=0.
- Latency: 1 cycle. in_sum sampled at edge k appears on out_sample at edge k, visible in cycle k+1.
- out_valid is the registered in_valid: high exactly one cycle per accepted input.
- Throughput: 1 sample/clock. in_valid gaps of any length are allowed and do not change state.
- Reset asserted mid-stream: all outputs go to their reset values immediately. The first in_valid after release is decoded with zero history.
- N=1: hist is a single register; x[n] = s[n] − s[n−1] + x[n−1].
- Wrap-around of in_sum is not modelled. Upstream sums never exceed SUM_WIDTH; any excursion shows up as saturation plus range_err.

## Test plan
All scenarios use WIDTH=8, N=4, SHIFT=2 unless stated.
- Ramp: in_sum = 1,3,6,10,14,18 on consecutive cycles -> out_sample = 1,2,3,4,5,6, each one cycle later; out_valid high 6 cycles; range_err=0.
- Loop-back: default params. Random signed 16-bit x drives the filter's internal sum (unshifted); that sum feeds this block -> out_sample equals x delayed by exactly 1 cycle for 10,000 samples.
- Gaps: ramp from the first scenario with in_valid low for 3 cycles between the 3rd and 4th samples -> identical output values; out_valid low during the gap; out_sample holds 3 through the gap.
- Saturation: first sample in_sum=200 -> out_sample=127, range_err=1. Then in_sum=−100 -> diff=−300, hist[3]=0 -> out_sample=−128, range_err stays 1. Then err_clr=1 with no saturation -> range_err=0.
- Flush: after the ramp reaches 6, assert flush with in_valid=1 and in_sum=7 -> out_sample=7. Next in_sum=9 -> out_sample=2 (history fully cleared).
- Reset mid-stream: assert rst during the ramp -> out_valid=0, out_sample=0 asynchronously. After release, in_sum=5 -> out_sample=5.

Source files
------------

// File: rtl/moving_avg_srl_inverse.sv
// Rebuilds raw samples from an N-point running-sum stream: x[n] = s[n] - s[n-1] + x[n-N].
// Latency 1 cycle, 1 sample/clk; no backpressure, every in_valid is accepted.
module moving_avg_srl_inverse #(
    parameter int WIDTH = 16,
    parameter int N     = 16,
    parameter int SHIFT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic signed [WIDTH+SHIFT-1:0]   in_sum,
    input  logic                            flush,
    input  logic                            err_clr,
    output logic                            out_valid,
    output logic signed [WIDTH-1:0]         out_sample,
    output logic                            range_err
);

    localparam int SW = WIDTH + SHIFT;
    localparam int MW = $clog2(N + 1);
    localparam logic signed [SW+1:0] MAX_R = (SW+2)'(2**(WIDTH-1) - 1);
    localparam logic signed [SW+1:0] MIN_R = ~MAX_R;

    logic signed [SW-1:0]    prev_sum_q, prev_sum_d, prev_eff;
    logic [MW-1:0]           mask_q, mask_d;
    logic [WIDTH-1:0]        srl_q [N];
    logic signed [WIDTH-1:0] hist_last, xs;
    logic signed [SW:0]      diff;
    logic signed [SW+1:0]    r;
    logic                    sat_hi, sat_lo;
    logic                    out_valid_q, range_err_q;
    logic signed [WIDTH-1:0] out_sample_q;

    // The delay line has no reset so it can map to SRLs; the mask counter
    // hides stale taps until N fresh samples have entered after reset/flush.
    always_comb begin
        prev_eff  = flush ? '0 : prev_sum_q;
        hist_last = (!flush && mask_q == MW'(N)) ? $signed(srl_q[N-1]) : '0;
        diff      = {in_sum[SW-1], in_sum} - {prev_eff[SW-1], prev_eff};
        r         = {diff[SW], diff} + {{(SW+2-WIDTH){hist_last[WIDTH-1]}}, hist_last};
        sat_hi    = (r > MAX_R);
        sat_lo    = (r < MIN_R);
        if (sat_hi)
            xs = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sat_lo)
            xs = {1'b1, {(WIDTH-1){1'b0}}};
        else
            xs = r[WIDTH-1:0];

        prev_sum_d = prev_sum_q;
        if (in_valid)
            prev_sum_d = in_sum;
        else if (flush)
            prev_sum_d = '0;

        mask_d = mask_q;
        if (flush)
            mask_d = in_valid ? MW'(1) : '0;
        else if (in_valid && mask_q != MW'(N))
            mask_d = mask_q + MW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            range_err_q  <= 1'b0;
            prev_sum_q   <= '0;
            mask_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid)
                out_sample_q <= xs;
            if (in_valid && (sat_hi || sat_lo))
                range_err_q <= 1'b1;
            else if (err_clr)
                range_err_q <= 1'b0;
            prev_sum_q <= prev_sum_d;
            mask_q     <= mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            srl_q[0] <= xs;
            for (int i = 1; i < N; i++)
                srl_q[i] <= srl_q[i-1];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign range_err  = range_err_q;

endmodule

// File: tb/tb_moving_avg_srl_inverse.sv
// Scoreboard bench: small config (W8/N4) for directed cases, default config for random loop-back.
module tb_moving_avg_srl_inverse;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance: WIDTH=8, N=4, SHIFT=2
    logic              in_valid_a, flush_a, err_clr_a;
    logic signed [9:0] in_sum_a;
    logic              out_valid_a, range_err_a;
    logic signed [7:0] out_sample_a;

    // default instance: WIDTH=16, N=16, SHIFT=4
    logic               in_valid_b, flush_b, err_clr_b;
    logic signed [19:0] in_sum_b;
    logic               out_valid_b, range_err_b;
    logic signed [15:0] out_sample_b;

    moving_avg_srl_inverse #(.WIDTH(8), .N(4), .SHIFT(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_sum(in_sum_a),
        .flush(flush_a), .err_clr(err_clr_a), .out_valid(out_valid_a),
        .out_sample(out_sample_a), .range_err(range_err_a)
    );

    moving_avg_srl_inverse dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_sum(in_sum_b),
        .flush(flush_b), .err_clr(err_clr_b), .out_valid(out_valid_b),
        .out_sample(out_sample_b), .range_err(range_err_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_a[$];
    int exp_b[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_out", 1, 0);
            else chk("a_sample", longint'(out_sample_a), longint'(exp_a.pop_front()));
        end
        if (!rst && out_valid_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_out", 1, 0);
            else chk("b_loopback", longint'(out_sample_b), longint'(exp_b.pop_front()));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the sample is captured.
    task automatic send_a(input int s, input bit fl, input int exp);
        in_valid_a = 1'b1;
        in_sum_a   = 10'(s);
        flush_a    = fl;
        exp_a.push_back(exp);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        flush_a    = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr_a = 1'b1;
        @(posedge clk);
        #1;
        err_clr_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ramp_s[6] = '{1, 3, 6, 10, 14, 18};
        int hx[16];
        int sum;
        int x;

        rst = 1'b1;
        in_valid_a = 1'b0; in_sum_a = '0; flush_a = 1'b0; err_clr_a = 1'b0;
        in_valid_b = 1'b0; in_sum_b = '0; flush_b = 1'b0; err_clr_b = 1'b0;
        #2;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_sample", out_sample_a, 0);
        chk("rst_range_err", range_err_a, 0);
        chk("rst_b_out_valid", out_valid_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ramp
        for (int i = 0; i < 6; i++) send_a(ramp_s[i], 1'b0, i + 1);
        chk("ramp_range_err", range_err_a, 0);

        // flush with a valid sample, then history must be empty
        send_a(7, 1'b1, 7);
        send_a(9, 1'b0, 2);

        // flush without valid: no output, state cleared
        flush_a = 1'b1;
        @(posedge clk);
        #1;
        flush_a = 1'b0;
        chk("flush_novld_out_valid", out_valid_a, 0);

        // ramp with a 3-cycle gap after the third sample
        for (int i = 0; i < 3; i++) send_a(ramp_s[i], 1'b0, i + 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("gap_out_valid", out_valid_a, 0);
            chk("gap_hold", out_sample_a, 3);
        end
        for (int i = 3; i < 6; i++) send_a(ramp_s[i], 1'b0, i + 1);

        // reset mid-stream
        send_a(1, 1'b1, 1);
        send_a(3, 1'b0, 2);
        in_valid_a = 1'b1;
        in_sum_a   = 10'(6);
        @(posedge clk);
        #2;
        in_valid_a = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid_a, 0);
        chk("midrst_out_sample", out_sample_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_a(5, 1'b0, 5);

        // saturation: set, sticky, clear, set-wins-over-clear
        send_a(200, 1'b1, 127);
        chk("sat_hi_err", range_err_a, 1);
        send_a(-100, 1'b0, -128);
        chk("sat_lo_err", range_err_a, 1);
        pulse_err_clr();
        chk("err_clr", range_err_a, 0);
        err_clr_a = 1'b1;
        send_a(300, 1'b0, 127);
        err_clr_a = 1'b0;
        chk("set_wins_clr", range_err_a, 1);
        pulse_err_clr();
        chk("err_clr2", range_err_a, 0);

        // exact limits do not saturate
        send_a(127, 1'b1, 127);
        chk("limit_hi_no_err", range_err_a, 0);
        send_a(-1, 1'b0, -128);
        chk("limit_lo_no_err", range_err_a, 0);

        // loop-back against a running-sum model on the default instance
        foreach (hx[i]) hx[i] = 0;
        sum = 0;
        for (int n = 0; n < 10000; n++) begin
            x = int'($urandom_range(65535)) - 32768;
            sum = sum + x - hx[n % 16];
            hx[n % 16] = x;
            in_valid_b = 1'b1;
            in_sum_b   = 20'(sum);
            exp_b.push_back(x);
            @(posedge clk);
            #1;
        end
        in_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b_range_err", range_err_b, 0);
        chk("a_queue_drained", exp_a.size(), 0);
        chk("b_queue_drained", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
